mode_debouncer: RTL and testbench
=================================

// Module: mode_debouncer
// PURPOSE
//   Conditions the raw, asynchronous mode button that drives the counter's `in`
//   (mode-select) input.
//   - Synchronises the button into the clk domain and rejects glitches and
//     bounce shorter than DEB_CYCLES clocks.
//   - Produces a clean mode level plus one-cycle rise/fall pulses and a press count.
//   - mode_out connects directly to the counter's `in` port.
// PARAMETERS
//   SYNC_STAGES  2   synchroniser flops; legal values >= 2
//   DEB_CYCLES   4   consecutive stable synchronised samples needed to accept a change; legal values >= 2
//   CNT_W        3   debounce counter width; 2**CNT_W must be >= DEB_CYCLES
//   TOGGLE       0   0: mode_out follows db_level; 1: mode_out flips on each accepted press
//   PCNT_W       4   press counter width
// PORTS
//   clk        in   1        system clock; all logic on the rising edge
//   rst        in   1        synchronous, active-high reset
//   btn_raw    in   1        raw button, asynchronous to clk, may bounce
//   mode_out   out  1        mode level to the counter `in` input
//   db_level   out  1        debounced button level
//   rise       out  1        one-cycle pulse when a high level is accepted
//   fall       out  1        one-cycle pulse when a low level is accepted
//   press_cnt  out  PCNT_W   number of accepted presses, modulo 2**PCNT_W
// BEHAVIOUR
//   - Reset: when rst=1 at an edge, all of the following are cleared to 0 and the
//     FSM goes to S_LO: synchroniser flops, cnt, db_level, mode_out, rise, fall,
//     press_cnt. Reset overrides every other event in that cycle.
//   - Synchroniser: s = output of the last of SYNC_STAGES flops in series. The FSM
//     samples only s, never btn_raw.
//   - FSM (all outputs registered):
//     - S_LO, s=1: go to S_LO_CHK, cnt<=1.
//     - S_LO_CHK, s=0: return to S_LO, cnt<=0. This is a rejected glitch; no pulse.
//     - S_LO_CHK, s=1, cnt==DEB_CYCLES-1: go to S_HI, db_level<=1, rise<=1,
//       press_cnt<=press_cnt+1, cnt<=0.
//     - S_LO_CHK, s=1, otherwise: cnt<=cnt+1.
//     - S_HI, S_HI_CHK: mirror of the above with s inverted. Acceptance sets
//       db_level<=0 and fall<=1. press_cnt is unchanged on a fall.
//   - rise and fall are high for exactly one cycle and are never high in the same cycle.
//   - Latency, with btn_raw stable and the first sampling edge counted as edge 1:
//     db_level changes, and rise or fall pulses, on edge SYNC_STAGES+DEB_CYCLES
//     (edge 6 with defaults).
//   - mode_out:
//     - TOGGLE=0: mode_out == db_level, registered on the same edge.
//     - TOGGLE=1: mode_out inverts on the edge where rise is set; it is unaffected by fall.
//   - press_cnt wraps from 2**PCNT_W-1 to 0 with no saturation and no flag.
//   - Bounce: any return of s to the previous level inside a CHK state restarts the
//     qualification from zero.
//   - Reset during a CHK state aborts qualification; no pulse is generated.
// STRUCTURE
//   - Shared package: FSM state encoding (2-bit: S_LO=0, S_LO_CHK=1, S_HI=2,
//     S_HI_CHK=3) and the DEB_CYCLES default. The counter bench reuses both.
//   - Sub-module: sync_ff, a parameterised SYNC_STAGES-deep synchroniser with
//     synchronous reset. Everything else stays in one FSM always block plus an
//     output register block.
// TESTING (defaults, 20 ns clock, rst asserted 2 cycles at start)
//   1. Reset: drive btn_raw=1 during rst -> all outputs 0 while rst=1; rise on
//      edge 6 after rst drops; press_cnt=1.
//   2. Clean press: btn_raw 0->1 held 10 cycles, then 1->0 -> db_level=1 and rise
//      pulse on edge 6; fall pulse 6 edges after release; press_cnt=1.
//   3. Bounce: btn_raw pattern 1,0,1,1,0,1 (one cycle each), then held 1 ->
//      exactly one rise, timed from the last 0->1 transition; no fall.
//   4. Glitch: 3-cycle high pulse on btn_raw -> no rise, db_level stays 0,
//      press_cnt unchanged.
//   5. TOGGLE=1, 3 clean presses -> mode_out goes 1,0,1 on each rise edge.
//      Connected counter: counts 0,1,2,... while mode_out=0, alternates 1/4 while mode_out=1.
//   6. Wrap and mid-reset: 16 presses -> press_cnt returns to 0. rst pulse in
//      S_LO_CHK with cnt=2 -> FSM in S_LO, no rise.

Source files
------------

// File: rtl/mode_debouncer_pkg.sv
// Purpose : shared encodings for the mode-button debouncer and the benches around it.
// Latency : n/a (types and constants only).
// Backpressure : n/a.
//
// Contents: 2-bit FSM state encoding and default qualification parameters.
package mode_debouncer_pkg;

    typedef enum logic [1:0] {
        S_LO     = 2'd0,
        S_LO_CHK = 2'd1,
        S_HI     = 2'd2,
        S_HI_CHK = 2'd3
    } deb_state_t;

    localparam int DEB_CYCLES_DEF  = 4;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/mode_debouncer_if.sv
// Purpose : bundles the raw button input and the conditioned mode outputs.
// Latency : n/a (wiring only).
// Backpressure : none; every output is a level or a single-cycle pulse.
//
// master : the debouncer (consumes btn_raw, drives the rest)
// slave  : button source / downstream counter
interface mode_debouncer_if #(
    parameter int PCNT_W = 4
);
    logic              btn_raw;
    logic              mode_out;
    logic              db_level;
    logic              rise;
    logic              fall;
    logic [PCNT_W-1:0] press_cnt;

    modport master (
        input  btn_raw,
        output mode_out,
        output db_level,
        output rise,
        output fall,
        output press_cnt
    );

    modport slave (
        output btn_raw,
        input  mode_out,
        input  db_level,
        input  rise,
        input  fall,
        input  press_cnt
    );
endinterface

// File: rtl/mode_debouncer_sync_ff.sv
// Purpose : STAGES-deep flop chain bringing an asynchronous level into clk.
// Latency : q reflects d after STAGES rising edges.
// Backpressure : none.
//
// Ports: clk, rst (sync, active-high), d (async in), q (synchronised out).
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/mode_debouncer.sv
// Purpose : debounces the mode button into a clean level, rise/fall pulses and a press count.
// Latency : outputs change SYNC_STAGES+DEB_CYCLES edges after btn_raw settles.
// Backpressure : none; pulses are one cycle wide and are not held for a consumer.
//
// Ports: clk, rst (sync, active-high), bus (mode_debouncer_if.master):
//   btn_raw in, mode_out/db_level/rise/fall/press_cnt out.
module mode_debouncer
    import mode_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int CNT_W       = 3,
    parameter int TOGGLE      = 0,
    parameter int PCNT_W      = 4
) (
    input  logic clk,
    input  logic rst,
    mode_debouncer_if.master bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    deb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             s;
    logic             acc_hi;
    logic             acc_lo;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.btn_raw),
        .q   (s)
    );

    // Acceptance happens on the DEB_CYCLES-th consecutive sample at the new level.
    assign acc_hi = (state == S_LO_CHK) &&  s && (cnt == CNT_LAST);
    assign acc_lo = (state == S_HI_CHK) && !s && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LO;
            cnt   <= '0;
        end else begin
            case (state)
                S_LO: begin
                    if (s) begin
                        state <= S_LO_CHK;
                        cnt   <= CNT_W'(1);
                    end
                end
                S_LO_CHK: begin
                    if (!s) begin
                        state <= S_LO;      // bounce back: start over
                        cnt   <= '0;
                    end else if (acc_hi) begin
                        state <= S_HI;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                    end
                end
                S_HI: begin
                    if (!s) begin
                        state <= S_HI_CHK;
                        cnt   <= CNT_W'(1);
                    end
                end
                S_HI_CHK: begin
                    if (s) begin
                        state <= S_HI;
                        cnt   <= '0;
                    end else if (acc_lo) begin
                        state <= S_LO;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Outputs are registered from the same acceptance terms so they move on the
    // same edge as the FSM transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.db_level  <= 1'b0;
            bus.rise      <= 1'b0;
            bus.fall      <= 1'b0;
            bus.press_cnt <= '0;
            bus.mode_out  <= 1'b0;
        end else begin
            bus.rise <= acc_hi;
            bus.fall <= acc_lo;
            if (acc_hi) begin
                bus.db_level  <= 1'b1;
                bus.press_cnt <= bus.press_cnt + 1'b1;
            end else if (acc_lo) begin
                bus.db_level  <= 1'b0;
            end
            if (TOGGLE != 0) begin
                if (acc_hi) bus.mode_out <= ~bus.mode_out;
            end else begin
                if (acc_hi)      bus.mode_out <= 1'b1;
                else if (acc_lo) bus.mode_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mode_debouncer.sv
// Purpose : directed bench for mode_debouncer (level mode and toggle mode instances).
// Latency : n/a.
// Backpressure : n/a.
module tb_mode_debouncer;
    import mode_debouncer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b1;

    int n_cmp      = 0;
    int n_fail     = 0;
    int rise_seen  = 0;
    int fall_seen  = 0;
    int both_seen  = 0;

    always #10 clk = ~clk;

    mode_debouncer_if #(.PCNT_W(4)) bus0 ();
    mode_debouncer_if #(.PCNT_W(4)) bus1 ();

    assign bus0.btn_raw = btn;
    assign bus1.btn_raw = btn;

    mode_debouncer #(.TOGGLE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mode_debouncer #(.TOGGLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n edges, sampling 1 ns after each rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus0.rise) rise_seen++;
            if (bus0.fall) fall_seen++;
            if (bus0.rise && bus0.fall) both_seen++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic clr_seen();
        rise_seen = 0;
        fall_seen = 0;
        both_seen = 0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. reset with the button already held
        tick(2);
        chk("rst_db",    bus0.db_level,  0);
        chk("rst_rise",  bus0.rise,      0);
        chk("rst_fall",  bus0.fall,      0);
        chk("rst_pcnt",  bus0.press_cnt, 0);
        chk("rst_mode",  bus0.mode_out,  0);
        chk("rst_tmode", bus1.mode_out,  0);
        rst = 1'b0;
        tick(5);
        chk("r1_rise_e5", bus0.rise, 0);
        tick(1);
        chk("r1_rise_e6", bus0.rise,      1);
        chk("r1_db_e6",   bus0.db_level,  1);
        chk("r1_pcnt",    bus0.press_cnt, 1);
        tick(1);
        chk("r1_rise_e7", bus0.rise, 0);

        // 2. clean press after a fresh reset
        btn = 1'b0;
        do_reset();
        tick(4);
        btn = 1'b1;
        tick(5);
        chk("p_db_e5",   bus0.db_level, 0);
        chk("p_rise_e5", bus0.rise,     0);
        tick(1);
        chk("p_db_e6",   bus0.db_level,  1);
        chk("p_rise_e6", bus0.rise,      1);
        chk("p_pcnt",    bus0.press_cnt, 1);
        chk("p_mode",    bus0.mode_out,  1);
        tick(1);
        chk("p_rise_e7", bus0.rise, 0);
        tick(3);
        btn = 1'b0;
        tick(5);
        chk("p_fall_e5", bus0.fall,     0);
        chk("p_db_hold", bus0.db_level, 1);
        tick(1);
        chk("p_fall_e6", bus0.fall,      1);
        chk("p_db_low",  bus0.db_level,  0);
        chk("p_pcnt_f",  bus0.press_cnt, 1);
        chk("p_mode_f",  bus0.mode_out,  0);
        tick(1);
        chk("p_fall_e7", bus0.fall, 0);

        // 3. bounce 1,0,1,1,0,1 then held
        tick(4);
        clr_seen();
        btn = 1'b1; tick(1);
        btn = 1'b0; tick(1);
        btn = 1'b1; tick(1);
        tick(1);
        btn = 1'b0; tick(1);
        btn = 1'b1;
        tick(5);
        chk("b_none_e5", rise_seen, 0);
        tick(1);
        chk("b_rise_e6", bus0.rise, 1);
        tick(6);
        chk("b_one_rise", rise_seen, 1);
        chk("b_no_fall",  fall_seen, 0);
        btn = 1'b0;
        tick(8);
        chk("b_pcnt", bus0.press_cnt, 2);
        chk("b_db",   bus0.db_level,  0);

        // 4. 3-cycle glitch rejected, 4-cycle pulse accepted
        clr_seen();
        btn = 1'b1; tick(3);
        btn = 1'b0; tick(10);
        chk("g3_rise", rise_seen,      0);
        chk("g3_db",   bus0.db_level,  0);
        chk("g3_pcnt", bus0.press_cnt, 2);
        btn = 1'b1; tick(4);
        btn = 1'b0; tick(2);
        chk("g4_rise", bus0.rise,      1);
        chk("g4_pcnt", bus0.press_cnt, 3);
        tick(8);
        chk("g4_fall", fall_seen,     1);
        chk("g4_db",   bus0.db_level, 0);
        chk("no_both", both_seen,     0);

        // 5. toggle mode: 1,0,1 on successive rises, unaffected by falls
        do_reset();
        tick(4);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] exp_t;
            exp_t = (i % 2 == 0) ? 32'd1 : 32'd0;
            btn = 1'b1;
            tick(6);
            chk("t_mode_rise", bus1.mode_out, exp_t);
            chk("l_mode_rise", bus0.mode_out, 1);
            tick(4);
            btn = 1'b0;
            tick(8);
            chk("t_mode_fall", bus1.mode_out, exp_t);
            chk("l_mode_fall", bus0.mode_out, 0);
        end
        chk("t_pcnt", bus1.press_cnt, 3);

        // 6. wrap after 16 presses
        do_reset();
        tick(4);
        for (int i = 0; i < 15; i++) begin
            btn = 1'b1; tick(8);
            btn = 1'b0; tick(8);
        end
        chk("w_pcnt15", bus0.press_cnt, 15);
        btn = 1'b1; tick(8);
        chk("w_pcnt0", bus0.press_cnt, 0);
        btn = 1'b0; tick(8);

        // mid-qualification reset in S_LO_CHK with cnt=2
        btn = 1'b1;
        tick(4);
        chk("m_state_chk", dut0.state, S_LO_CHK);
        chk("m_cnt2",      dut0.cnt,   2);
        rst = 1'b1;
        btn = 1'b0;
        tick(1);
        rst = 1'b0;
        chk("m_state_lo", dut0.state, S_LO);
        clr_seen();
        tick(10);
        chk("m_no_rise",  rise_seen,      0);
        chk("m_pcnt",     bus0.press_cnt, 0);
        chk("m_state_end", dut0.state,    S_LO);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
